// File: rtl/inv_sub_bytes_seq.sv
// AES-128 inverse SubBytes stage, LANES S-box lookups per cycle.
// Input register is walked chunk by chunk into the output register.
module inv_sub_bytes_seq #(
  parameter int NWords = 4,
  parameter int LANES  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NWords*32-1:0]  bytes_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NWords*32-1:0]  bytes_out
);

  localparam int NB = 4 * NWords;
  localparam int C  = NB / LANES;
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam int LW = 8 * LANES;

  generate
    if ((NB % LANES) != 0) begin : g_bad_lanes
      $error("LANES must divide 4*NWords");
    end
  endgenerate

  // FIPS-197 inverse S-box, entry 0 in the top byte
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad5_3036a538_bf40a39e_81f3d7fb,
    128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
    128'h547b9432_a6c2233d_ee4c950b_42fac34e,
    128'h082ea166_28d924b2_765ba249_6d8bd125,
    128'h72f8f664_866898_16_d4a45ccc_5d65b692,
    128'h6c704850_fdedb9da_5e154657_a78d9d84,
    128'h90d8ab00_8cbcd30a_f7e45805_b8b34506,
    128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
    128'h3a911141_4f67dcea_97f2cfce_f0b4e673,
    128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
    128'h47f11a71_1d29c589_6fb7620e_aa18be1b,
    128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
    128'h1fdda833_8807c731_b1121059_2780ec5f,
    128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
    128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961,
    128'h172b047e_ba77d626_e1691463_55210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [C-1:0][LW-1:0]   in_q, in_d;
  logic [C-1:0][LW-1:0]   out_q, out_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [LANES-1:0][7:0]  chunk;
  logic [LANES-1:0][7:0]  sb;
  logic                   last;

  assign chunk = in_q[cnt_q];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign sb[g] = inv_sbox(chunk[g]);
  end

  assign last      = (cnt_q == CW'(C - 1));
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bytes_out = out_q;

  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_d    = bytes_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        out_d[cnt_q] = sb;
        if (last) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      in_q    <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq.
// Default instance plus LANES=1/2/16 copies for latency sweep.
module tb_inv_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] bytes_in;

  logic         rdy4, vld4, rdy1, vld1, rdy2, vld2, rdy16, vld16;
  logic [127:0] out4, out1, out2, out16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inv_sub_bytes_seq #(.NWords(4), .LANES(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy4),
    .bytes_in(bytes_in),
    .out_valid(vld4), .out_ready(out_ready),
    .bytes_out(out4)
  );

  inv_sub_bytes_seq #(.NWords(4), .LANES(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy1),
    .bytes_in(bytes_in),
    .out_valid(vld1), .out_ready(out_ready),
    .bytes_out(out1)
  );

  inv_sub_bytes_seq #(.NWords(4), .LANES(2)) u2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy2),
    .bytes_in(bytes_in),
    .out_valid(vld2), .out_ready(out_ready),
    .bytes_out(out2)
  );

  inv_sub_bytes_seq #(.NWords(4), .LANES(16)) u16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy16),
    .bytes_in(bytes_in),
    .out_valid(vld16), .out_ready(out_ready),
    .bytes_out(out16)
  );

  // forward S-box, entry 0 in the top byte
  localparam logic [2047:0] SBOX = {
    128'h637c777b_f26b6fc5_3001672b_fed7ab76,
    128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
    128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
    128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8,
    128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
    128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479,
    128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
    128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df,
    128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  localparam logic [127:0] B_IN  = 128'h63636363_7c7c7c7c_16161616_edededed;
  localparam logic [127:0] B_EXP = 128'h00000000_01010101_ffffffff_53535353;
  localparam logic [127:0] V_IN  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] V_EXP = 128'h52096ad5_3036a538_bf40a39e_81f3d7fb;

  function automatic logic [7:0] fwd(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic xfer(input string tag, input logic [127:0] din,
                      input logic [127:0] exp, input int lat);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    bytes_in = din;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!vld4 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, 128'(n), 128'(lat));
    chk({tag, "_out"}, out4, exp);
    @(posedge clk);
    #1;
    chk({tag, "_rdy"}, 128'(rdy4), 128'(1));
  endtask

  initial begin
    int n;
    logic seen;
    logic [127:0] din, exp;
    int l1, l2, l4, l16;
    logic [127:0] o1, o2, o4, o16;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bytes_in  = '0;
    #12;
    chk("rst_rdy", 128'(rdy4), 128'(1));
    chk("rst_vld", 128'(vld4), 128'(0));
    chk("rst_out", out4, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    out_ready = 1'b1;
    xfer("basic", B_IN, B_EXP, 4);

    // backpressure with noisy input side
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    bytes_in = V_IN;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!vld4 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_lat", 128'(n), 128'(4));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(1) == 1);
      bytes_in = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      chk("bp_vld", 128'(vld4), 128'(1));
      chk("bp_rdy", 128'(rdy4), 128'(0));
      chk("bp_out", out4, V_EXP);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_xfer_vld", 128'(vld4), 128'(0));
    chk("bp_xfer_rdy", 128'(rdy4), 128'(1));

    // async reset while holding a result
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    bytes_in = B_IN;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("done_vld", 128'(vld4), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rdy", 128'(rdy4), 128'(1));
    chk("arst_vld", 128'(vld4), 128'(0));
    chk("arst_out", out4, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // reset in the middle of RUN
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    bytes_in = V_IN;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      seen = seen | vld4;
    end
    chk("rmr_novld", 128'(seen), 128'(0));
    chk("rmr_rdy", 128'(rdy4), 128'(1));
    xfer("rmr_next", B_IN, B_EXP, 4);

    // round trip over all 256 byte values
    for (int s = 0; s < 16; s++) begin
      for (int i = 0; i < 16; i++) begin
        din[8*i +: 8] = fwd(8'(16 * s + i));
        exp[8*i +: 8] = 8'(16 * s + i);
      end
      xfer($sformatf("rt%0d", s), din, exp, 4);
    end

    // LANES sweep from a clean reset
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    bytes_in = B_IN;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    l1 = 0; l2 = 0; l4 = 0; l16 = 0;
    o1 = '0; o2 = '0; o4 = '0; o16 = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (l1 == 0 && vld1) begin l1 = k; o1 = out1; end
      if (l2 == 0 && vld2) begin l2 = k; o2 = out2; end
      if (l4 == 0 && vld4) begin l4 = k; o4 = out4; end
      if (l16 == 0 && vld16) begin l16 = k; o16 = out16; end
    end
    chk("sw1_lat", 128'(l1), 128'(16));
    chk("sw2_lat", 128'(l2), 128'(8));
    chk("sw4_lat", 128'(l4), 128'(4));
    chk("sw16_lat", 128'(l16), 128'(1));
    chk("sw1_out", o1, B_EXP);
    chk("sw2_out", o2, B_EXP);
    chk("sw4_out", o4, B_EXP);
    chk("sw16_out", o16, B_EXP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
